// File: rtl/mem_io_responder_if.sv
// ---------------------------------------------------------------------------
// mem_io_responder_if
// Byte-wide CPU RAM/IO bus between the CPU memory controller (master) and
// the RAM/IO responder (slave).
//
// Signals:
//   cpu_a    [31:0]  byte address, master -> slave (only [17:0] decoded)
//   cpu_wr           1 = write, 0 = read, master -> slave
//   cpu_dout [7:0]   write data, master -> slave
//   cpu_din  [7:0]   registered read data, slave -> master
//
// Handshake: this bus has no valid/ready pair. Every clock cycle is one
// transaction: the slave samples cpu_a/cpu_wr/cpu_dout at each rising edge,
// and read data for a read issued in cycle N appears on cpu_din in cycle N+1.
// A write returns 0x00 on cpu_din in the following cycle.
// ---------------------------------------------------------------------------
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;

  modport master (
    output cpu_a,
    output cpu_wr,
    output cpu_dout,
    input  cpu_din
  );

  modport slave (
    input  cpu_a,
    input  cpu_wr,
    input  cpu_dout,
    output cpu_din
  );
endinterface

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Memory-side responder for the CPU byte bus: 2^ADDR_WIDTH byte RAM with a
// one-cycle registered read, plus an I/O window at cpu_a[17:16]==2'b11:
//   0x30000        UART: read pops RX FIFO, write pushes TX FIFO (0x00 ignored)
//   0x30004..07    cycle counter bytes (little-endian, snapshot on 0x30004)
//   write 0x30004  pushes 0x00 into TX and sets the sticky program_stop flag
//   other io addr  read 0x00, writes ignored
//
// Ports:
//   clk_in, rst_in    clock, synchronous active-high reset
//   bus               CPU bus (slave modport)
//   io_buffer_full    registered: TX count >= TX_DEPTH-2
//   tx_data/valid     TX FIFO head / non-empty; popped when tx_ready
//   tx_ready          UART takes tx_data this cycle
//   rx_data/valid     incoming UART byte
//   rx_ready          RX FIFO has room
//   program_stop      sticky stop flag, freezes the cycle counter
//   tx_overflow       sticky: a TX byte was dropped because the FIFO was full
//
// UART side handshake: a byte moves when valid and ready are both high at a
// rising edge; ready never depends combinationally on valid.
//
// CNT_RESET_VALUE only exists so a bench can start the counter near its wrap
// point; leave it at 0 in the SoC.
// ---------------------------------------------------------------------------
module mem_io_responder #(
  parameter int          ADDR_WIDTH      = 17,
  parameter int          TX_DEPTH        = 8,
  parameter int          RX_DEPTH        = 8,
  parameter logic [31:0] CNT_RESET_VALUE = 32'h0000_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  mem_io_responder_if.slave      bus,
  output logic                   io_buffer_full,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   program_stop,
  output logic                   tx_overflow
);

  localparam int TX_PTR_W = $clog2(TX_DEPTH);
  localparam int RX_PTR_W = $clog2(RX_DEPTH);
  localparam int TX_CNT_W = TX_PTR_W + 1;
  localparam int RX_CNT_W = RX_PTR_W + 1;

  localparam logic [TX_CNT_W-1:0] TX_FULL_CNT   = TX_CNT_W'(TX_DEPTH);
  localparam logic [TX_CNT_W-1:0] TX_NEARLY_CNT = TX_CNT_W'(TX_DEPTH - 2);
  localparam logic [RX_CNT_W-1:0] RX_FULL_CNT   = RX_CNT_W'(RX_DEPTH);

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [7:0] r_mem    [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] r_tx_mem [0:TX_DEPTH-1];
  logic [7:0] r_rx_mem [0:RX_DEPTH-1];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [7:0]          r_cpu_din;
  logic                r_prev_uart_rd;
  logic [31:0]         r_cnt;
  logic [31:0]         r_snap;
  logic                r_stop;
  logic                r_tx_ovf;
  logic                r_io_full;
  logic [TX_PTR_W-1:0] r_tx_wr_ptr;
  logic [TX_PTR_W-1:0] r_tx_rd_ptr;
  logic [TX_CNT_W-1:0] r_tx_count;
  logic [RX_PTR_W-1:0] r_rx_wr_ptr;
  logic [RX_PTR_W-1:0] r_rx_rd_ptr;
  logic [RX_CNT_W-1:0] r_rx_count;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_io;
  logic                  w_uart_sel;
  logic                  w_cnt_sel;
  logic [1:0]            w_cnt_k;
  logic                  w_uart_rd;
  logic                  w_uart_wr;
  logic                  w_stop_wr;
  logic                  w_ram_wr;
  logic                  w_snap_load;
  logic                  w_unused_addr;

  assign w_addr      = bus.cpu_a[ADDR_WIDTH-1:0];
  assign w_io        = (bus.cpu_a[17:16] == 2'b11);
  assign w_uart_sel  = (bus.cpu_a[17:0] == 18'h30000);
  assign w_cnt_sel   = (bus.cpu_a[17:2] == 16'hC001);   // 0x30004..0x30007
  assign w_cnt_k     = bus.cpu_a[1:0];
  assign w_uart_rd   = w_uart_sel & ~bus.cpu_wr;
  assign w_uart_wr   = w_uart_sel &  bus.cpu_wr;
  assign w_stop_wr   = w_cnt_sel & (w_cnt_k == 2'd0) & bus.cpu_wr;
  assign w_ram_wr    = ~w_io & bus.cpu_wr;
  assign w_snap_load = w_cnt_sel & (w_cnt_k == 2'd0) & ~bus.cpu_wr;

  // Upper address bits are deliberately ignored.
  assign w_unused_addr = ^bus.cpu_a[31:18];

  // ---------------------------------------------------------------------
  // RX FIFO control
  // ---------------------------------------------------------------------
  logic w_rx_push;
  logic w_rx_pop;
  logic w_rx_empty;

  assign w_rx_empty = (r_rx_count == '0);
  assign rx_ready   = (r_rx_count < RX_FULL_CNT);
  assign w_rx_push  = rx_valid & rx_ready;
  // Only the first cycle of a UART read run pops; the empty check uses the
  // pre-push count so a byte arriving into an empty FIFO is stored, not read.
  assign w_rx_pop   = w_uart_rd & ~r_prev_uart_rd & ~w_rx_empty;

  // ---------------------------------------------------------------------
  // TX FIFO control
  // ---------------------------------------------------------------------
  logic       w_tx_push_req;
  logic [7:0] w_tx_push_data;
  logic       w_tx_full;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic       w_tx_drop;

  assign w_tx_push_req  = (w_uart_wr & (bus.cpu_dout != 8'h00)) | w_stop_wr;
  assign w_tx_push_data = w_stop_wr ? 8'h00 : bus.cpu_dout;
  assign w_tx_full      = (r_tx_count == TX_FULL_CNT);
  assign tx_valid       = (r_tx_count != '0);
  assign tx_data        = r_tx_mem[r_tx_rd_ptr];
  assign w_tx_pop       = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_tx_push      = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_drop      = w_tx_push_req & w_tx_full & ~w_tx_pop;

  logic [TX_CNT_W-1:0] w_tx_count_nxt;
  logic [RX_CNT_W-1:0] w_rx_count_nxt;

  always_comb begin
    w_tx_count_nxt = r_tx_count;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_nxt = r_tx_count + TX_CNT_W'(1);
      2'b01:   w_tx_count_nxt = r_tx_count - TX_CNT_W'(1);
      default: w_tx_count_nxt = r_tx_count;
    endcase
  end

  always_comb begin
    w_rx_count_nxt = r_rx_count;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_count_nxt = r_rx_count + RX_CNT_W'(1);
      2'b01:   w_rx_count_nxt = r_rx_count - RX_CNT_W'(1);
      default: w_rx_count_nxt = r_rx_count;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read data selection
  // ---------------------------------------------------------------------
  logic [7:0] w_din_nxt;
  logic [7:0] w_cnt_byte;

  always_comb begin
    w_cnt_byte = 8'h00;
    case (w_cnt_k)
      // Byte 0 comes from the live counter; the same value is latched into
      // the snapshot, so bytes 1..3 read later stay coherent with it.
      2'd0:    w_cnt_byte = r_cnt[7:0];
      2'd1:    w_cnt_byte = r_snap[15:8];
      2'd2:    w_cnt_byte = r_snap[23:16];
      default: w_cnt_byte = r_snap[31:24];
    endcase
  end

  always_comb begin
    w_din_nxt = 8'h00;
    if (bus.cpu_wr) begin
      w_din_nxt = 8'h00;
    end else if (!w_io) begin
      w_din_nxt = r_mem[w_addr];
    end else if (w_uart_rd) begin
      if (r_prev_uart_rd) begin
        w_din_nxt = r_cpu_din;        // hold the byte for the whole run
      end else if (!w_rx_empty) begin
        w_din_nxt = r_rx_mem[r_rx_rd_ptr];
      end else begin
        w_din_nxt = 8'h00;
      end
    end else if (w_cnt_sel) begin
      w_din_nxt = w_cnt_byte;
    end else begin
      w_din_nxt = 8'h00;
    end
  end

  // ---------------------------------------------------------------------
  // Memories (no reset; RAM contents survive reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_ram_wr) begin
      r_mem[w_addr] <= bus.cpu_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= w_tx_push_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cpu_din      <= 8'h00;
      r_prev_uart_rd <= 1'b0;
      r_cnt          <= CNT_RESET_VALUE;
      r_snap         <= 32'h0;
      r_stop         <= 1'b0;
      r_tx_ovf       <= 1'b0;
      r_io_full      <= 1'b0;
      r_tx_wr_ptr    <= '0;
      r_tx_rd_ptr    <= '0;
      r_tx_count     <= '0;
      r_rx_wr_ptr    <= '0;
      r_rx_rd_ptr    <= '0;
      r_rx_count     <= '0;
    end else begin
      r_cpu_din      <= w_din_nxt;
      r_prev_uart_rd <= w_uart_rd;

      if (!r_stop) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_snap_load) begin
        r_snap <= r_cnt;
      end
      if (w_stop_wr) begin
        r_stop <= 1'b1;
      end
      if (w_tx_drop) begin
        r_tx_ovf <= 1'b1;
      end

      if (w_tx_push) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + TX_PTR_W'(1);
      end
      if (w_tx_pop) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + TX_PTR_W'(1);
      end
      r_tx_count <= w_tx_count_nxt;
      // Early warning leaves room for writes already issued by the CPU.
      r_io_full  <= (w_tx_count_nxt >= TX_NEARLY_CNT);

      if (w_rx_push) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + RX_PTR_W'(1);
      end
      if (w_rx_pop) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + RX_PTR_W'(1);
      end
      r_rx_count <= w_rx_count_nxt;
    end
  end

  assign bus.cpu_din     = r_cpu_din;
  assign program_stop    = r_stop;
  assign tx_overflow     = r_tx_ovf;
  assign io_buffer_full  = r_io_full;

endmodule
